instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL take parameter DATA_W, default 24: instruction width in bits.
REQ-002 SHALL take parameter ADDR_W, default 24: PC width; PC is a word address.
REQ-003 SHALL take parameter DEPTH, default 256: number of words, power of two, minimum 2.
REQ-004 SHALL take parameter NOP_INSTR, default all-zero DATA_W: fill and fault value.
REQ-005 Clock  in  1: single clock; all logic is rising-edge.
REQ-006 Reset  in  1: synchronous, active-low reset.
REQ-007 FetchValid  in  1: a fetch request is present.
REQ-008 PC  in  ADDR_W: fetch word address.
REQ-009 FetchReady  out  1: the block can accept a fetch this cycle.
REQ-010 InstrValid  out  1: Instruction and InstrFault are valid.
REQ-011 Instruction  out  DATA_W: fetched word.
REQ-012 InstrFault  out  1: the fetched PC was out of range.
REQ-013 InstrStall  in  1: downstream holds the current response.
REQ-014 ProgEn  in  1: program-port write strobe.
REQ-015 ProgAddr  in  log2(DEPTH): program write address.
REQ-016 ProgData  in  DATA_W: program write data.
REQ-017 Busy  out  1: initialisation fill is in progress.

Function
REQ-018 SHALL implement FSM states INIT and RUN; reset enters INIT with fill counter = 0.
REQ-019 INIT: each cycle writes NOP_INSTR to mem[counter] and increments the counter.
REQ-020 INIT transitions to RUN in the cycle after the write at counter = DEPTH-1, so the fill takes exactly DEPTH cycles.
REQ-021 Busy SHALL be 1 exactly while in INIT.
REQ-022 In INIT, ProgEn and FetchValid SHALL be ignored.
REQ-023 FetchReady SHALL be 1 when state = RUN and ProgEn = 0 and not (InstrValid and InstrStall).
REQ-024 A fetch is accepted when FetchValid and FetchReady are both 1.
REQ-025 Read latency SHALL be 1: the cycle after acceptance, InstrValid = 1 and Instruction = mem[PC[log2(DEPTH)-1:0]].
REQ-026 Out of range (any PC bit at or above log2(DEPTH) set): Instruction = NOP_INSTR, InstrFault = 1, with InstrValid still asserted.
REQ-027 In-range fetches SHALL give InstrFault = 0.
REQ-028 While InstrValid and InstrStall are both 1, Instruction, InstrFault and InstrValid SHALL hold unchanged and no fetch is accepted.
REQ-029 If no fetch is accepted and InstrStall = 0, InstrValid SHALL drop to 0 on the next cycle; Instruction holds its last value.
REQ-030 Back-to-back accepted fetches SHALL give one response per cycle, in order.
REQ-031 In RUN, ProgEn = 1 SHALL write ProgData to mem[ProgAddr] at the clock edge.
REQ-032 Program writes SHALL be allowed while a response is stalled and SHALL NOT alter the held Instruction.
REQ-033 A fetch accepted in a later cycle to an address written earlier SHALL return the new data (no stale read).

Reset
REQ-034 On Reset = 0 at a clock edge: InstrValid = 0, InstrFault = 0, Instruction = NOP_INSTR, FetchReady = 0, Busy = 1 from the next cycle, state = INIT, counter = 0.
REQ-035 Reset asserted mid-fill or mid-stall SHALL abort the operation and restart the fill from address 0; any pending response is discarded.
REQ-036 Reset SHALL dominate ProgEn, FetchValid and InstrStall.

Structure
REQ-037 The FSM state encoding and the default NOP_INSTR constant SHALL live in the shared CPU package.
REQ-038 The storage array SHALL be one sub-module, instr_ram: single write port and single synchronous read port, parametrised by DATA_W and DEPTH; instr_fetch_mem holds the FSM, fill counter, fault check and output register.

Verification
REQ-039 Reset, then hold Reset = 1 -> Busy = 1 for 256 cycles, then FetchReady = 1; fetch PC = 16 -> next cycle InstrValid = 1, Instruction = 24'h000000, InstrFault = 0.
REQ-040 Program mem[16] = 24'hA5C3F0, then fetch PC = 16 -> Instruction = 24'hA5C3F0 one cycle later.
REQ-041 Fetch PC = 24'h000100 (DEPTH = 256) -> InstrFault = 1, Instruction = 24'h000000, InstrValid = 1.
REQ-042 Fetch PC = 1, 2, 3 on consecutive cycles with InstrStall = 1 on response 2 for 3 cycles -> FetchReady = 0 during the stall, response 2 held, responses arrive in order 1, 2, 3.
REQ-043 Assert Reset at fill counter = 100, then release -> Busy stays 1 for a full 256 further cycles and InstrValid = 0 throughout.

Source files
------------

// File: rtl/instr_fetch_mem_pkg.sv
// Shared definitions for the instruction fetch memory.
// Holds the fetch FSM state encoding, the default fill/fault word and the PC range check.
package instr_fetch_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  localparam int NOP_W = 24;
  localparam logic [NOP_W-1:0] NOP_INSTR_DEFAULT = 24'h000000;

  // True when any PC bit at or above the storage index width is set.
  function automatic logic pc_out_of_range(input logic [63:0] pc, input int unsigned aw);
    return ((pc >> aw) != 64'd0);
  endfunction

endpackage

// File: rtl/instr_fetch_mem_ram.sv
// Instruction storage: one write port, one synchronous read port.
// The read register only updates on a read strobe, so a held response survives later writes.
module instr_ram
  import instr_fetch_mem_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Write port: store one word per strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word on a read strobe, otherwise hold.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: fills storage with NOPs after reset, then serves
// single-cycle-latency fetches with stall/hold and an out-of-range fault flag,
// while accepting program-port writes.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int                DATA_W    = 24,
  parameter int                ADDR_W    = 24,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     FetchValid,
  input  logic [ADDR_W-1:0]        PC,
  output logic                     FetchReady,
  output logic                     InstrValid,
  output logic [DATA_W-1:0]        Instruction,
  output logic                     InstrFault,
  input  logic                     InstrStall,
  input  logic                     ProgEn,
  input  logic [$clog2(DEPTH)-1:0] ProgAddr,
  input  logic [DATA_W-1:0]        ProgData,
  output logic                     Busy
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic [AW-1:0]     cnt_r;
  logic              fill_last_s;
  logic              busy_s;
  logic              run_s;
  logic              hold_s;
  logic              fetch_ready_s;
  logic              accept_s;
  logic              fault_s;
  logic              ram_we_s;
  logic [AW-1:0]     ram_waddr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;
  logic              valid_r;
  logic              fault_r;
  logic              nop_sel_r;

  assign fill_last_s = (cnt_r == AW'(DEPTH - 1));

  // State register: reset always restarts the fill.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: leave INIT after the last fill write, RUN is terminal until reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (fill_last_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = ST_INIT;
    endcase
  end

  // State decode: busy while filling, serving fetches while running.
  always_comb begin
    busy_s = 1'b0;
    run_s  = 1'b0;
    case (state_r)
      ST_INIT: busy_s = 1'b1;
      ST_RUN:  run_s  = 1'b1;
      default: busy_s = 1'b1;
    endcase
  end

  // A stalled valid response blocks new fetches; program writes take the port too.
  assign hold_s        = valid_r & InstrStall;
  assign fetch_ready_s = Reset & run_s & ~ProgEn & ~hold_s;
  assign accept_s      = FetchValid & fetch_ready_s;
  assign fault_s       = pc_out_of_range(64'(PC), AW);

  // Fill counter: walks every address once during INIT.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_r <= {AW{1'b0}};
    end else if (busy_s) begin
      cnt_r <= cnt_r + AW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Write port mux: fill NOPs in INIT, program writes in RUN, nothing under reset.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = ProgAddr;
    ram_wdata_s = ProgData;
    if (!Reset) begin
      ram_we_s = 1'b0;
    end else if (busy_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cnt_r;
      ram_wdata_s = NOP_INSTR;
    end else if (ProgEn) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  instr_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (accept_s),
    .raddr (PC[AW-1:0]),
    .rdata (ram_rdata_s)
  );

  // Response register: load on accept, hold while stalled, otherwise drop valid.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      valid_r   <= 1'b0;
      fault_r   <= 1'b0;
      nop_sel_r <= 1'b1;
    end else if (accept_s) begin
      valid_r   <= 1'b1;
      fault_r   <= fault_s;
      nop_sel_r <= fault_s;
    end else if (hold_s) begin
      valid_r   <= valid_r;
      fault_r   <= fault_r;
      nop_sel_r <= nop_sel_r;
    end else begin
      valid_r   <= 1'b0;
      fault_r   <= fault_r;
      nop_sel_r <= nop_sel_r;
    end
  end

  // Faulted fetches and the post-reset word read as NOP instead of RAM data.
  assign Instruction = nop_sel_r ? NOP_INSTR : ram_rdata_s;
  assign InstrValid  = valid_r;
  assign InstrFault  = fault_r;
  assign FetchReady  = fetch_ready_s;
  assign Busy        = busy_s;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem with a response scoreboard.
module tb_instr_fetch_mem;

  localparam int DEPTH = 256;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        FetchValid;
  logic [23:0] PC;
  logic        FetchReady;
  logic        InstrValid;
  logic [23:0] Instruction;
  logic        InstrFault;
  logic        InstrStall;
  logic        ProgEn;
  logic [7:0]  ProgAddr;
  logic [23:0] ProgData;
  logic        Busy;

  int checks = 0;
  int errors = 0;
  logic [23:0] model_mem [DEPTH];
  logic [24:0] exp_q [$];

  instr_fetch_mem #(
    .DATA_W    (24),
    .ADDR_W    (24),
    .DEPTH     (DEPTH),
    .NOP_INSTR (24'h000000)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .FetchValid  (FetchValid),
    .PC          (PC),
    .FetchReady  (FetchReady),
    .InstrValid  (InstrValid),
    .Instruction (Instruction),
    .InstrFault  (InstrFault),
    .InstrStall  (InstrStall),
    .ProgEn      (ProgEn),
    .ProgAddr    (ProgAddr),
    .ProgData    (ProgData),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] expect_for(input logic [23:0] pc);
    if (pc[23:8] != 16'd0) return {1'b1, 24'h000000};
    else return {1'b0, model_mem[pc[7:0]]};
  endfunction

  // Scoreboard: compare every visible response, retire it once not stalled.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && InstrValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", InstrValid, 1'b0);
      end else begin
        chk("resp_instr", Instruction, exp_q[0][23:0]);
        chk("resp_fault", InstrFault, exp_q[0][24]);
        if (InstrStall === 1'b0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clock); #1;
  endtask

  task automatic fetch(input logic [23:0] pc);
    FetchValid = 1'b1; PC = pc; #1;
    chk("fetch_ready", FetchReady, 1'b1);
    exp_q.push_back(expect_for(pc));
    @(posedge Clock); #1;
    chk("resp_latency", InstrValid, 1'b1);
    FetchValid = 1'b0;
  endtask

  task automatic prog(input logic [7:0] a, input logic [23:0] d);
    ProgEn = 1'b1; ProgAddr = a; ProgData = d; #1;
    chk("ready_during_prog", FetchReady, 1'b0);
    model_mem[a] = d;
    @(posedge Clock); #1;
    ProgEn = 1'b0;
  endtask

  // Expects to start one tick after the releasing edge; optionally drives ignored requests.
  task automatic fill_check(input bit noise);
    for (int i = 0; i < DEPTH; i++) begin
      if (noise && i == 0) begin
        FetchValid = 1'b1; PC = 24'd16;
        ProgEn = 1'b1; ProgAddr = 8'd16; ProgData = 24'hFFFFFF;
      end
      @(negedge Clock);
      chk("fill_busy", Busy, 1'b1);
      chk("fill_valid", InstrValid, 1'b0);
      chk("fill_ready", FetchReady, 1'b0);
      if (noise && i == DEPTH - 8) begin
        FetchValid = 1'b0; ProgEn = 1'b0;
      end
    end
    @(negedge Clock);
    chk("run_busy", Busy, 1'b0);
    chk("run_ready", FetchReady, 1'b1);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 24'h000000;
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset = 1'b0; FetchValid = 1'b0; PC = 24'd0; InstrStall = 1'b0;
    ProgEn = 1'b0; ProgAddr = 8'd0; ProgData = 24'd0;
    step(); step();
    chk("rst_busy", Busy, 1'b1);
    chk("rst_valid", InstrValid, 1'b0);
    chk("rst_fault", InstrFault, 1'b0);
    chk("rst_instr", Instruction, 24'h000000);
    chk("rst_ready", FetchReady, 1'b0);
    Reset = 1'b1;
    fill_check(1'b1);

    // Fill result, ignored INIT writes, programmed data, faults.
    fetch(24'd16); step();
    prog(8'd16, 24'hA5C3F0); fetch(24'd16); step();
    fetch(24'h000100); step();
    fetch(24'h800010); step();
    prog(8'd255, 24'h123456); prog(8'd0, 24'h00ABCD);
    fetch(24'd255); fetch(24'd0); step();

    // Back-to-back with a three-cycle stall on the second response.
    prog(8'd1, 24'h111111); prog(8'd2, 24'h222222); prog(8'd3, 24'h333333);
    fetch(24'd1); fetch(24'd2);
    InstrStall = 1'b1; FetchValid = 1'b1; PC = 24'd3; #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_ready", FetchReady, 1'b0);
      chk("stall_valid", InstrValid, 1'b1);
      chk("stall_instr", Instruction, 24'h222222);
      if (k == 1) begin
        ProgEn = 1'b1; ProgAddr = 8'd2; ProgData = 24'hBEEF01; model_mem[2] = 24'hBEEF01;
      end else begin
        ProgEn = 1'b0;
      end
      @(posedge Clock); #2;
    end
    InstrStall = 1'b0; #1;
    chk("unstall_ready", FetchReady, 1'b1);
    exp_q.push_back(expect_for(24'd3));
    @(posedge Clock); #1;
    chk("resp3_valid", InstrValid, 1'b1);
    FetchValid = 1'b0;
    step();
    chk("idle_valid_drop", InstrValid, 1'b0);
    fetch(24'd2); step();

    // Reset during a stalled response discards it.
    fetch(24'd5); InstrStall = 1'b1; step();
    chk("held_valid", InstrValid, 1'b1);
    Reset = 1'b0; exp_q.delete(); FetchValid = 1'b1; ProgEn = 1'b1;
    step();
    chk("rst2_valid", InstrValid, 1'b0);
    chk("rst2_fault", InstrFault, 1'b0);
    chk("rst2_instr", Instruction, 24'h000000);
    chk("rst2_busy", Busy, 1'b1);
    chk("rst2_ready", FetchReady, 1'b0);
    InstrStall = 1'b0; FetchValid = 1'b0; ProgEn = 1'b0; Reset = 1'b1;

    // Reset again at fill counter 100; the fill restarts in full.
    for (int i = 0; i < 100; i++) begin
      chk("part_busy", Busy, 1'b1);
      chk("part_valid", InstrValid, 1'b0);
      step();
    end
    Reset = 1'b0; step();
    chk("rst3_busy", Busy, 1'b1);
    chk("rst3_valid", InstrValid, 1'b0);
    Reset = 1'b1;
    fill_check(1'b0);
    fetch(24'd2); step();
    step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
